crc_multi_hash: RTL and testbench
=================================

# crc_multi_hash

Streaming multi-hash generator for the bloom-filter datapath. Accepts a key as a byte stream (1..N bytes per beat, packet-framed) and computes NUM_HASH independent CRC-16 (poly 0x8D95, x^16+x^15+x^11+x^10+x^8+x^7+x^4+x^2+1) hashes in parallel. Each channel uses a distinct seed and is reduced to HASH_W bits. It sits between the key-parsing front end and the bloom-filter bit-array address ports, and delivers one hash vector per key through a registered valid/ready output.

## Interface
- NUM_HASH, default 4: number of parallel hash channels, 1..20; channel k seeded with 16'(k+1)
- HASH_W, default 12: output bits per hash, 1..16
- DATA_BYTES, default 1: bytes per input beat, 1..8
- clk_i  in  1  clock; one clock domain
- rst_i  in  1  reset, asynchronous, active-high
- data_i  in  8*DATA_BYTES  key bytes; data_i[7:0] is processed first
- valid_i  in  1  input beat valid
- last_i  in  1  final beat of key
- empty_i  in  $clog2(DATA_BYTES)+1  count of unused high bytes on the last beat; ignored when last_i=0
- ready_o  out  1  input beat accepted when valid_i & ready_o
- hash_o  out  NUM_HASH*HASH_W  hash_o[k*HASH_W +: HASH_W] = channel k
- hash_valid_o  out  1  hash vector available
- hash_ready_i  in  1  consumer accepts vector when hash_valid_o & hash_ready_i

## Operation
- FSM states: IDLE (no key in progress), ACC (key in progress).
- IDLE + accepted beat: each channel's CRC state = CRC over the beat's valid bytes starting from seed k+1; if last_i then complete, stay IDLE, else go to ACC.
- ACC + accepted beat: fold valid bytes into the current state; on last_i complete and return to IDLE.
- Valid bytes per beat: DATA_BYTES on non-last beats; DATA_BYTES-empty_i on the last beat. Clamp empty_i to DATA_BYTES-1, so a beat always carries at least one byte.
- Bytes within a beat are chained combinationally with the 8-bit CRC-0x8D95 step, low byte first. The step does not reflect or XOR the output.
- Completion: hash_o loads the reduced state of every channel and hash_valid_o sets.
- Reduction (default): hash = crc[HASH_W-1:0], plain truncation.
- ready_o = ~hash_valid_o | hash_ready_i. Backpressure applies only through the single output holding register. Mid-packet beats stall together with last beats.
- Output pop without a new completion in the same cycle clears hash_valid_o. A simultaneous pop and completion leaves hash_valid_o at 1 and loads the new vector.
- hash_o holds its last value after a pop.
- valid_i=0 in ACC: state is held, with no timeout.

## Timing
- Reset values: ready_o=1, hash_valid_o=0, hash_o=0, FSM=IDLE, CRC states=seeds.
- Latency: last beat accepted at edge N gives hash_valid_o=1 and the new hash_o after edge N (visible in cycle N+1).
- Throughput: one beat per cycle. Back-to-back single-beat keys run at one vector per cycle while hash_ready_i=1.
- ready_o is combinational from hash_valid_o and hash_ready_i only, with no path from valid_i.
- hash_o and hash_valid_o are driven directly from flops.
- Reset asserted mid-packet: the partial key is discarded and the output is cleared immediately, because reset is asynchronous. After release the next accepted beat starts a new key.

## Configuration
- CRC_MULTI_HASH_FOLD_EN defined: the reduction is the XOR of all HASH_W-bit chunks of the 16-bit CRC, with the top chunk zero-padded. For HASH_W=12 this gives crc[11:0] ^ {8'h0, crc[15:12]}. For HASH_W=16 it is identical to truncation.
- CRC_MULTI_HASH_FOLD_EN undefined: plain truncation.
- The macro changes only the reduction logic. Latency and handshake are unchanged.

## Test plan
- Single-byte key, NUM_HASH=4, HASH_W=12, DATA_BYTES=1: key 0x00 (valid_i=1, last_i=1) -> one cycle later hash_valid_o=1, channels 0..3 = 0x100, 0x200, 0x300, 0x400.
- Two-byte key 0x00,0x00 over two beats, no fold -> channel 0 = 0xD95, channel 1 = 0x6BF. With CRC_MULTI_HASH_FOLD_EN defined -> 0xD9D, 0x6B6.
- DATA_BYTES=2, single beat data_i=16'h0000, empty_i=0 -> same result as the previous scenario. The same beat with empty_i=1 -> same result as the single-byte 0x00 key.
- Backpressure: hash_ready_i=0 after one completion -> ready_o=0 and a second key stalls with no loss. Raise hash_ready_i -> first vector popped, the second completes one cycle after acceptance, and ordering is preserved.
- Pop plus completion in the same cycle with hash_ready_i=1 and back-to-back keys -> hash_valid_o stays 1 for consecutive cycles, with each vector distinct and correct.
- Assert rst_i mid-way through a two-beat key (after beat 1) -> outputs are zero immediately. After release, the key 0x00 alone -> 0x100, 0x200, 0x300, 0x400, with no residue from the partial key.

Source files
------------

// File: rtl/crc_multi_hash.sv
// -----------------------------------------------------------------------------
// crc_multi_hash
//
// Streaming multi-hash generator for the bloom-filter datapath. A key arrives
// as a packet-framed byte stream (1..DATA_BYTES bytes per beat, data_i[7:0]
// first). NUM_HASH CRC-16 channels (poly 0x8D95, non-reflected, no output XOR)
// run in parallel; channel k starts from seed k+1. At the end of each key every
// channel is reduced to HASH_W bits and the whole vector is presented through
// a single registered valid/ready holding register.
//
// Optional feature macro: CRC_MULTI_HASH_FOLD_EN
//   undefined : hash = crc[HASH_W-1:0]
//   defined   : hash = XOR of all HASH_W-bit chunks of crc (top chunk
//               zero-padded)
//
// Ports
//   clk_i        in   clock
//   rst_i        in   asynchronous active-high reset
//   data_i       in   key bytes, low byte processed first
//   valid_i      in   input beat valid
//   last_i       in   final beat of the key
//   empty_i      in   unused high bytes on the last beat (clamped)
//   ready_o      out  beat accepted when valid_i & ready_o
//   hash_o       out  hash_o[k*HASH_W +: HASH_W] = channel k
//   hash_valid_o out  hash vector available
//   hash_ready_i in   consumer takes the vector when valid & ready
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module crc_multi_hash #(
    parameter int NUM_HASH   = 4,
    parameter int HASH_W     = 12,
    parameter int DATA_BYTES = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [8*DATA_BYTES-1:0]      data_i,
    input  logic                         valid_i,
    input  logic                         last_i,
    input  logic [$clog2(DATA_BYTES):0]  empty_i,
    output logic                         ready_o,
    output logic [NUM_HASH*HASH_W-1:0]   hash_o,
    output logic                         hash_valid_o,
    input  logic                         hash_ready_i
);

    localparam int          EW   = $clog2(DATA_BYTES) + 1;
    localparam logic [15:0] POLY = 16'h8D95;

    typedef enum logic {IDLE, ACC} state_t;

    state_t                       state_q, state_d;
    logic [15:0]                  crc_q   [NUM_HASH];
    logic [15:0]                  crc_d   [NUM_HASH];
    logic [15:0]                  crc_new [NUM_HASH];
    logic [NUM_HASH*HASH_W-1:0]   hash_q, hash_d, hash_red;
    logic                         hash_valid_q, hash_valid_d;
    logic                         accept, complete, pop;
    logic [EW-1:0]                empty_c;
    logic [3:0]                   n_valid;

    // One byte through the MSB-first CRC-16 register.
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ((r << 1) ^ POLY) : (r << 1);
        end
        return r;
    endfunction

    function automatic logic [HASH_W-1:0] reduce(input logic [15:0] c);
`ifdef CRC_MULTI_HASH_FOLD_EN
        logic [HASH_W-1:0] r;
        r = '0;
        // Shifting in zeros pads the top chunk automatically.
        for (int s = 0; s < 16; s += HASH_W) begin
            r = r ^ HASH_W'(c >> s);
        end
        return r;
`else
        return c[HASH_W-1:0];
`endif
    endfunction

    // ready_o depends only on the holding register and the consumer.
    assign ready_o  = ~hash_valid_q | hash_ready_i;
    assign accept   = valid_i & ready_o;
    assign complete = accept & last_i;
    assign pop      = hash_valid_q & hash_ready_i;

    // Byte count of this beat; empty_i is clamped so a beat never carries zero bytes.
    always_comb begin
        empty_c = empty_i;
        if (empty_i > EW'(DATA_BYTES - 1)) begin
            empty_c = EW'(DATA_BYTES - 1);
        end
        n_valid = last_i ? (4'(DATA_BYTES) - 4'(empty_c)) : 4'(DATA_BYTES);
    end

    generate
        for (genvar gi = 0; gi < NUM_HASH; gi++) begin : g_chan
            logic [15:0] chain;

            // A new key starts from the seed regardless of what crc_q holds.
            always_comb begin
                chain = (state_q == IDLE) ? 16'(gi + 1) : crc_q[gi];
                for (int j = 0; j < DATA_BYTES; j++) begin
                    if (4'(j) < n_valid) begin
                        chain = crc_byte(chain, data_i[8*j +: 8]);
                    end
                end
            end

            assign crc_new[gi]                      = chain;
            assign hash_red[gi*HASH_W +: HASH_W]    = reduce(chain);
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        hash_d       = hash_q;
        hash_valid_d = hash_valid_q;
        for (int k = 0; k < NUM_HASH; k++) begin
            crc_d[k] = crc_q[k];
        end

        if (accept) begin
            if (last_i) begin
                state_d = IDLE;
                for (int k = 0; k < NUM_HASH; k++) begin
                    crc_d[k] = 16'(k + 1);
                end
            end else begin
                state_d = ACC;
                for (int k = 0; k < NUM_HASH; k++) begin
                    crc_d[k] = crc_new[k];
                end
            end
        end

        // A completion wins over a pop, so back-to-back keys keep valid high.
        if (complete) begin
            hash_d       = hash_red;
            hash_valid_d = 1'b1;
        end else if (pop) begin
            hash_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            hash_q       <= '0;
            hash_valid_q <= 1'b0;
            for (int k = 0; k < NUM_HASH; k++) begin
                crc_q[k] <= 16'(k + 1);
            end
        end else begin
            state_q      <= state_d;
            hash_q       <= hash_d;
            hash_valid_q <= hash_valid_d;
            for (int k = 0; k < NUM_HASH; k++) begin
                crc_q[k] <= crc_d[k];
            end
        end
    end

    assign hash_o       = hash_q;
    assign hash_valid_o = hash_valid_q;

endmodule

// File: tb/tb_crc_multi_hash.sv
// -----------------------------------------------------------------------------
// tb_crc_multi_hash
//
// Scoreboard bench for crc_multi_hash (NUM_HASH=4, HASH_W=12, DATA_BYTES=2).
// The driver pushes the expected vector when a last beat is accepted; an
// independent monitor pops and compares on every output handshake.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_crc_multi_hash;

    localparam int NH = 4;
    localparam int HW = 12;
    localparam int DB = 2;
    localparam int EW = 2;

    logic               clk = 1'b0;
    logic               rst_i;
    logic [8*DB-1:0]    data_i;
    logic               valid_i;
    logic               last_i;
    logic [EW-1:0]      empty_i;
    logic               ready_o;
    logic [NH*HW-1:0]   hash_o;
    logic               hash_valid_o;
    logic               hash_ready_i;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int run_len = 0;
    int max_run = 0;
    logic [NH*HW-1:0] exp_q[$];

    crc_multi_hash #(
        .NUM_HASH   (NH),
        .HASH_W     (HW),
        .DATA_BYTES (DB)
    ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .last_i       (last_i),
        .empty_i      (empty_i),
        .ready_o      (ready_o),
        .hash_o       (hash_o),
        .hash_valid_o (hash_valid_o),
        .hash_ready_i (hash_ready_i)
    );

    always #5 clk = ~clk;

    // Bit-serial reference CRC, key byte 0 first.
    function automatic logic [15:0] ref_crc(input logic [15:0] seed, input logic [63:0] key, input int n);
        logic [15:0] c;
        logic        fb;
        c = seed;
        for (int i = 0; i < n; i++) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ key[8*i + b];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h8D95;
            end
        end
        return c;
    endfunction

    function automatic logic [HW-1:0] ref_red(input logic [15:0] c);
`ifdef CRC_MULTI_HASH_FOLD_EN
        return c[11:0] ^ {8'h00, c[15:12]};
`else
        return c[11:0];
`endif
    endfunction

    function automatic logic [NH*HW-1:0] hand_vec(input logic [15:0] c0, input logic [15:0] c1,
                                                  input logic [15:0] c2, input logic [15:0] c3);
        return {ref_red(c3), ref_red(c2), ref_red(c1), ref_red(c0)};
    endfunction

    function automatic logic [NH*HW-1:0] model_vec(input logic [63:0] key, input int n);
        logic [NH*HW-1:0] v;
        v = '0;
        for (int k = 0; k < NH; k++) begin
            v[k*HW +: HW] = ref_red(ref_crc(16'(k + 1), key, n));
        end
        return v;
    endfunction

    // Monitor: handshake-driven scoreboard pop plus ready_o relation.
    always @(negedge clk) begin
        if (!rst_i) begin
            checks++;
            if (ready_o !== (~hash_valid_o | hash_ready_i)) begin
                errors++;
                $display("FAIL ready_rel: ready_o=%b hash_valid_o=%b hash_ready_i=%b", ready_o, hash_valid_o, hash_ready_i);
            end
            if (hash_valid_o && hash_ready_i) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_vec: got hash_o=%h with empty scoreboard", hash_o);
                end else begin
                    logic [NH*HW-1:0] e;
                    e = exp_q.pop_front();
                    pops++;
                    if (hash_o !== e) begin
                        errors++;
                        $display("FAIL vec%0d: hash_o=%h expected %h", pops, hash_o, e);
                    end else begin
                        $display("pop %0d: hash_o=%h ok", pops, hash_o);
                    end
                end
            end else begin
                run_len = 0;
            end
        end
    end

    // Call with time at posedge+1; returns at posedge+1 after acceptance.
    task automatic send_beat(input logic [8*DB-1:0] d, input logic l, input logic [EW-1:0] e,
                             input logic [NH*HW-1:0] exp_v);
        bit accepted;
        accepted = 1'b0;
        data_i   = d;
        last_i   = l;
        empty_i  = e;
        valid_i  = 1'b1;
        for (int t = 0; t < 200 && !accepted; t++) begin
            @(negedge clk);
            if (ready_o) begin
                @(posedge clk);
                accepted = 1'b1;
            end
        end
        #1;
        valid_i = 1'b0;
        last_i  = 1'b0;
        if (!accepted) begin
            errors++;
            $display("FAIL accept_timeout: beat %h never accepted", d);
        end else if (l) begin
            exp_q.push_back(exp_v);
            checks++;
            if (hash_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL latency: hash_valid_o=%b one cycle after last beat, expected 1", hash_valid_o);
            end
        end
    endtask

    task automatic send_key(input logic [63:0] key, input int n, input logic [NH*HW-1:0] exp_v);
        int off;
        int rem;
        int take;
        off = 0;
        rem = n;
        while (rem > 0) begin
            take = (rem > DB) ? DB : rem;
            send_beat(key[8*off +: 16], (rem <= DB), EW'(DB - take), exp_v);
            off += take;
            rem -= take;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && exp_q.size() > 0; t++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d vectors still expected", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [NH*HW-1:0] got, input logic [NH*HW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    initial begin
        rst_i        = 1'b1;
        data_i       = '0;
        valid_i      = 1'b0;
        last_i       = 1'b0;
        empty_i      = '0;
        hash_ready_i = 1'b1;
        #1;
        check("reset_hash", hash_o, '0);
        check("reset_valid", 48'(hash_valid_o), 48'd0);
        check("reset_ready", 48'(ready_o), 48'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Single byte 0x00 (one valid byte in a 2-byte beat).
        send_key(64'h00, 1, hand_vec(16'h0100, 16'h0200, 16'h0300, 16'h0400));
        // Two bytes 0x00,0x00 in one beat.
        send_key(64'h0000, 2, hand_vec(16'h8D95, 16'h96BF, 16'h1B2A, 16'hA0EB));
        // Oversized empty_i clamps to one byte; high byte ignored.
        send_beat(16'hAB00, 1'b1, 2'd3, hand_vec(16'h0100, 16'h0200, 16'h0300, 16'h0400));
        // Multi-beat keys through the ACC state.
        send_key(64'h000000, 3, model_vec(64'h000000, 3));
        send_key(64'h0504030201, 5, model_vec(64'h0504030201, 5));
        send_key(64'hDEADBEEFCAFEF00D, 8, model_vec(64'hDEADBEEFCAFEF00D, 8));
        drain();

        // Backpressure: second key must stall behind the held vector.
        hash_ready_i = 1'b0;
        send_key(64'h11, 1, model_vec(64'h11, 1));
        fork
            send_key(64'h22, 1, model_vec(64'h22, 1));
        join_none
        repeat (3) @(negedge clk);
        check("bp_ready", 48'(ready_o), 48'd0);
        check("bp_valid", 48'(hash_valid_o), 48'd1);
        check("bp_hold", hash_o, model_vec(64'h11, 1));
        @(posedge clk);
        #1;
        hash_ready_i = 1'b1;
        wait fork;
        drain();

        // Back-to-back single-beat keys: pop and completion coincide.
        @(posedge clk);
        #1;
        max_run = 0;
        send_key(64'h11, 1, model_vec(64'h11, 1));
        send_key(64'hA5B6, 2, model_vec(64'hA5B6, 2));
        send_key(64'hFF, 1, model_vec(64'hFF, 1));
        send_key(64'h0201, 2, model_vec(64'h0201, 2));
        drain();
        check("b2b_run", 48'(max_run), 48'd4);

        // Reset in the middle of a two-beat key.
        send_key(64'h5A, 1, model_vec(64'h5A, 1));
        send_beat(16'h0000, 1'b0, 2'd0, '0);
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_mid_hash", hash_o, '0);
        check("rst_mid_valid", 48'(hash_valid_o), 48'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        send_key(64'h00, 1, hand_vec(16'h0100, 16'h0200, 16'h0300, 16'h0400));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
